mips32_run_sequencer: RTL and testbench
=======================================

MIPS32_RUN_SEQUENCER -- requirements
Module: mips32_run_sequencer

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 8, meaning instruction-memory word-address width (256 words).
REQ-002 The block SHALL have parameter MAX_CYCLES, default 1024, meaning the RUN-phase cycle limit before timeout.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-004 The block SHALL have port start in 1, a request to begin a load/run/dump sequence.
REQ-005 The block SHALL have ports load_valid in 1, load_ready out 1, load_data in 32 and load_last in 1, forming the program word stream.
REQ-006 The block SHALL have ports imem_we out 1, imem_waddr out IMEM_AW and imem_wdata out 32, forming the instruction memory write port.
REQ-007 The block SHALL have ports cpu_rst_n out 1 (core reset, active-low), cpu_en out 1 (core clock-enable) and cpu_pc in 32 (core byte PC).
REQ-008 The block SHALL have ports reg_raddr out 5 and reg_rdata in 32, forming the combinational register-file read port.
REQ-009 The block SHALL have ports dump_valid out 1, dump_ready in 1, dump_data out 32 and dump_last out 1, forming the register dump stream.
REQ-010 The block SHALL have status ports busy out 1, done out 1, err_timeout out 1 and cycle_count out 16.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, RUN, DUMP and DONE.
REQ-012 IDLE/DONE: start=1 SHALL go to LOAD next cycle, clear write address, cycle_count and err_timeout; start outside IDLE/DONE SHALL be ignored.
REQ-013 LOAD: load_ready=1; a transfer SHALL occur when load_valid&load_ready; imem_we=load_valid&load_ready combinationally, imem_wdata=load_data, imem_waddr=word counter.
REQ-014 On each transfer the word counter SHALL increment; prog_len SHALL be counter+1.
REQ-015 A transfer with load_last=1, or a transfer at address 2^IMEM_AW-1 (memory full, implicit last), SHALL go to RUN next cycle.
REQ-016 cpu_rst_n SHALL be 0 in IDLE and LOAD, and 1 in RUN, DUMP and DONE, so the core starts at PC 0 on RUN entry.
REQ-017 RUN: cpu_en=1; cycle_count SHALL increment every RUN cycle, saturating at 16'hFFFF.
REQ-018 RUN SHALL exit to DUMP when cpu_pc >= prog_len*4 (program fell through).
REQ-019 RUN SHALL exit to DUMP with err_timeout=1 when cycle_count reaches MAX_CYCLES.
REQ-020 If both RUN exit conditions hold in the same cycle, the PC condition SHALL win (err_timeout stays 0).
REQ-021 DUMP: cpu_en=0 (core frozen); index 0..31 SHALL drive reg_raddr; dump_valid=1, dump_data=reg_rdata and dump_last=(index==31).
REQ-022 In DUMP, the index SHALL advance only on dump_valid&dump_ready; dump_data SHALL be held stable while dump_ready=0.
REQ-023 Acceptance of the last dump word SHALL go to DONE.
REQ-024 DONE: done=1 and the core stays out of reset with cpu_en=0.
REQ-025 busy SHALL be 1 in LOAD, RUN and DUMP; load_ready, imem_we, cpu_en and dump_valid SHALL be 0 in all other states.

Reset
REQ-026 rst_n low SHALL force, asynchronously, state IDLE, cpu_rst_n=0, all counters 0, and all other outputs 0, including mid-LOAD, RUN or DUMP.
REQ-027 After reset release, start SHALL be required before any memory write occurs.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the register count (32) and the instruction width (32).
REQ-029 The dump stream SHALL be a sub-module mips32_reg_dumper (index counter plus valid/ready logic); everything else SHALL stay in one module.

Verification
REQ-030 The bench SHALL cover: reset, then start plus 3 words (last on the 3rd) -> imem writes at addresses 0,1,2; RUN entered; exits when cpu_pc=12; done=1.
REQ-031 The bench SHALL cover: load_valid toggling 1,0,1,1 with last on the 3rd word -> exactly 3 writes; waddr never skips.
REQ-032 The bench SHALL cover: core PC looping at 0 with MAX_CYCLES=16 -> DUMP after 16 RUN cycles; err_timeout=1; cycle_count=16.
REQ-033 The bench SHALL cover: DUMP with dump_ready low for 5 cycles at index 4 -> reg_raddr=4 and dump_data stable; 32 words total; dump_last only on word 31.
REQ-034 The bench SHALL cover: 256 words without load_last -> RUN entered after the word at address 255; prog_len=256.
REQ-035 The bench SHALL cover: rst_n asserted mid-RUN -> same cycle cpu_rst_n=0 and cpu_en=0; after release the block stays IDLE until start.

Source files
------------

// File: rtl/mips32_run_sequencer_pkg.sv
// Shared definitions for the MIPS32 load/run/dump sequencer.
// Holds the sequencer FSM state enum and the register-file and instruction
// geometry that the top level and the register dumper both depend on.
package mips32_run_sequencer_pkg;

    localparam int unsigned NumRegs      = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned InstrWidth   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDump,
        StDone
    } seq_state_e;

endpackage

// File: rtl/mips32_reg_dumper.sv
// Register dump stream: walks register indices 0..NumRegs-1 over a
// valid/ready stream while enabled.
//   clk_i, rst_ni        clock, async active-low reset
//   en_i                 dump phase active (drives dump_valid_o)
//   reg_raddr_o          register-file read address (current index)
//   reg_rdata_i          combinational register-file read data
//   dump_valid_o/_ready_i/_data_o/_last_o   outgoing register stream
//   finish_o             the last word is being accepted this cycle
module mips32_reg_dumper
    import mips32_run_sequencer_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    output logic [RegAddrWidth-1:0] reg_raddr_o,
    input  logic [31:0]             reg_rdata_i,
    output logic                    dump_valid_o,
    input  logic                    dump_ready_i,
    output logic [31:0]             dump_data_o,
    output logic                    dump_last_o,
    output logic                    finish_o
);

    localparam logic [RegAddrWidth-1:0] LastIdx = RegAddrWidth'(NumRegs - 1);

    logic [RegAddrWidth-1:0] idx_q, idx_d;
    logic                    accept;
    logic                    at_last;

    assign accept  = en_i & dump_ready_i;
    assign at_last = (idx_q == LastIdx);

    // Index wraps to 0 after the last word so the next dump starts clean.
    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = at_last ? '0 : idx_q + RegAddrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // The core is frozen during the dump, so read data is stable while the
    // index is held by a stalled consumer.
    assign reg_raddr_o  = idx_q;
    assign dump_valid_o = en_i;
    assign dump_data_o  = en_i ? reg_rdata_i : '0;
    assign dump_last_o  = en_i & at_last;
    assign finish_o     = accept & at_last;

endmodule

// File: rtl/mips32_run_sequencer.sv
// Load/run/dump sequencer for a MIPS32 core under test.
// Streams a program into instruction memory, releases the core from reset and
// runs it until the PC falls past the program or a cycle limit expires, then
// streams out all registers.
//   clk_i, rst_ni                     clock, async active-low reset
//   start_i                           begin a sequence (honoured in idle/done)
//   load_valid_i/_ready_o/_data_i/_last_i   incoming program word stream
//   imem_we_o/_waddr_o/_wdata_o       instruction memory write port
//   cpu_rst_n_o, cpu_en_o, cpu_pc_i   core reset, clock-enable, byte PC
//   reg_raddr_o, reg_rdata_i          register-file read port
//   dump_valid_o/_ready_i/_data_o/_last_o   register dump stream
//   busy_o, done_o, err_timeout_o, cycle_count_o   status
module mips32_run_sequencer
    import mips32_run_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned MAX_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [InstrWidth-1:0]   load_data_i,
    input  logic                    load_last_i,
    output logic                    imem_we_o,
    output logic [IMEM_AW-1:0]      imem_waddr_o,
    output logic [InstrWidth-1:0]   imem_wdata_o,
    output logic                    cpu_rst_n_o,
    output logic                    cpu_en_o,
    input  logic [31:0]             cpu_pc_i,
    output logic [RegAddrWidth-1:0] reg_raddr_o,
    input  logic [31:0]             reg_rdata_i,
    output logic                    dump_valid_o,
    input  logic                    dump_ready_i,
    output logic [31:0]             dump_data_o,
    output logic                    dump_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_timeout_o,
    output logic [15:0]             cycle_count_o
);

    seq_state_e         state_q, state_d;
    logic [IMEM_AW-1:0] waddr_q, waddr_d;
    logic [IMEM_AW:0]   prog_len_q, prog_len_d;
    logic [15:0]        cycle_q, cycle_d;
    logic               err_q, err_d;

    // Output flags registered from the next state so they line up with state_q.
    logic load_ready_q;
    logic cpu_rst_n_q;
    logic cpu_en_q;
    logic dump_en_q;
    logic busy_q;
    logic done_q;

    logic        load_fire;
    logic        mem_full;
    logic [15:0] cycle_inc;
    logic [31:0] pc_limit;
    logic        pc_exit;
    logic        time_exit;
    logic        dump_finish;

    assign load_fire = load_ready_q & load_valid_i;
    assign mem_full  = (waddr_q == {IMEM_AW{1'b1}});
    assign cycle_inc = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;
    assign pc_limit  = 32'({prog_len_q, 2'b00});
    assign pc_exit   = (cpu_pc_i >= pc_limit);
    // Fires on the RUN cycle that brings the count up to the limit.
    assign time_exit = ({16'd0, cycle_inc} >= MAX_CYCLES);

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        prog_len_d = prog_len_q;
        cycle_d    = cycle_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d    = StLoad;
                    waddr_d    = '0;
                    prog_len_d = '0;
                    cycle_d    = '0;
                    err_d      = 1'b0;
                end
            end
            StLoad: begin
                if (load_fire) begin
                    waddr_d    = waddr_q + IMEM_AW'(1);
                    prog_len_d = {1'b0, waddr_q} + {{IMEM_AW{1'b0}}, 1'b1};
                    // A write to the top address is an implicit last word.
                    if (load_last_i || mem_full) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cycle_d = cycle_inc;
                // PC fall-through takes priority over the timeout.
                if (pc_exit) begin
                    state_d = StDump;
                end else if (time_exit) begin
                    state_d = StDump;
                    err_d   = 1'b1;
                end
            end
            StDump: begin
                if (dump_finish) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            waddr_q      <= '0;
            prog_len_q   <= '0;
            cycle_q      <= '0;
            err_q        <= 1'b0;
            load_ready_q <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            cpu_en_q     <= 1'b0;
            dump_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            prog_len_q   <= prog_len_d;
            cycle_q      <= cycle_d;
            err_q        <= err_d;
            load_ready_q <= (state_d == StLoad);
            cpu_rst_n_q  <= (state_d == StRun) || (state_d == StDump) || (state_d == StDone);
            cpu_en_q     <= (state_d == StRun);
            dump_en_q    <= (state_d == StDump);
            busy_q       <= (state_d == StLoad) || (state_d == StRun) || (state_d == StDump);
            done_q       <= (state_d == StDone);
        end
    end

    mips32_reg_dumper u_dumper (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (dump_en_q),
        .reg_raddr_o  (reg_raddr_o),
        .reg_rdata_i  (reg_rdata_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .finish_o     (dump_finish)
    );

    assign load_ready_o  = load_ready_q;
    assign imem_we_o     = load_fire;
    assign imem_waddr_o  = waddr_q;
    assign imem_wdata_o  = load_ready_q ? load_data_i : '0;
    assign cpu_rst_n_o   = cpu_rst_n_q;
    assign cpu_en_o      = cpu_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_mips32_run_sequencer.sv
// Self-checking bench for mips32_run_sequencer (MAX_CYCLES=16, 256-word imem).
// A simple core model drives the PC; a register array answers reads.
module tb_mips32_run_sequencer;

    localparam int MaxCyc = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        cpu_en;
    logic [31:0] cpu_pc;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] cycle_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];
    int          core_mode;
    logic [31:0] core_jump;
    logic [31:0] core_pc;

    typedef struct {
        int          len;
        int          mode;      // 0: PC stuck at 0, 1: PC steps +4, 2: PC jumps to jump
        logic [31:0] jump;
        bit          use_last;
        logic [3:0]  pat;       // nonzero: cyclic load_valid pattern, bit 0 first
        bit          stall4;    // hold dump_ready low 5 cycles at index 4
        int          exp_cycles;
        bit          exp_err;
    } vec_t;

    mips32_run_sequencer #(
        .IMEM_AW    (8),
        .MAX_CYCLES (MaxCyc)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .load_valid_i  (load_valid),
        .load_ready_o  (load_ready),
        .load_data_i   (load_data),
        .load_last_i   (load_last),
        .imem_we_o     (imem_we),
        .imem_waddr_o  (imem_waddr),
        .imem_wdata_o  (imem_wdata),
        .cpu_rst_n_o   (cpu_rst_n),
        .cpu_en_o      (cpu_en),
        .cpu_pc_i      (cpu_pc),
        .reg_raddr_o   (reg_raddr),
        .reg_rdata_i   (reg_rdata),
        .dump_valid_o  (dump_valid),
        .dump_ready_i  (dump_ready),
        .dump_data_o   (dump_data),
        .dump_last_o   (dump_last),
        .busy_o        (busy),
        .done_o        (done),
        .err_timeout_o (err_timeout),
        .cycle_count_o (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: reset forces PC 0; enabled cycles advance per mode.
    always @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            core_pc <= 32'd0;
        end else if (cpu_en) begin
            case (core_mode)
                1:       core_pc <= core_pc + 32'd4;
                2:       core_pc <= core_jump;
                default: core_pc <= 32'd0;
            endcase
        end
    end
    assign cpu_pc    = core_pc;
    assign reg_rdata = regs[reg_raddr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RUN length from the exit rules: PC >= 4*len ends the run (checked
    // first); otherwise the run ends with a timeout on RUN cycle MaxCyc.
    function automatic void model_run(input int len, input int mode, input logic [31:0] jump,
                                      output int cyc, output bit err);
        longint pc;
        cyc = 0;
        err = 1'b0;
        for (int k = 1; k <= MaxCyc; k++) begin
            if (mode == 1)               pc = 4 * (k - 1);
            else if (mode == 2 && k > 1) pc = longint'(jump);
            else                         pc = 0;
            if (pc >= 4 * len) begin
                cyc = k;
                err = 1'b0;
                return;
            end
            if (k >= MaxCyc) begin
                cyc = k;
                err = 1'b1;
                return;
            end
        end
    endfunction

    // Runs one full start/load/run/dump sequence; entered and left at a negedge.
    task automatic run_vec(input vec_t t);
        int w, wr, cyc, runc, idx, stall;
        bit v;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        core_mode = t.mode;
        core_jump = t.jump;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        w = 0; wr = 0; cyc = 0;
        while (w < t.len && cyc < 2000) begin
            v          = (t.pat != 4'd0) ? t.pat[cyc % 4] : ($urandom_range(99) >= 30);
            load_valid = v;
            load_data  = $urandom;
            load_last  = t.use_last && (w == t.len - 1);
            start      = ($urandom_range(3) == 0);
            #1;
            chk("load_ready", {31'd0, load_ready}, 1);
            chk("busy_load", {31'd0, busy}, 1);
            chk("cpu_rst_n_load", {31'd0, cpu_rst_n}, 0);
            chk("imem_we", {31'd0, imem_we}, {31'd0, v});
            if (imem_we) begin
                wr++;
                chk("imem_waddr", {24'd0, imem_waddr}, {24'd0, w[7:0]});
                chk("imem_wdata", imem_wdata, load_data);
            end
            @(posedge clk);
            if (v) w++;
            cyc++;
            @(negedge clk);
        end
        chk("words_written", wr, t.len);
        load_last = 1'b0;

        runc = 0; cyc = 0;
        while (cyc < 200) begin
            load_valid = $urandom_range(1);
            start      = ($urandom_range(3) == 0);
            #1;
            if (dump_valid) break;
            runc++;
            chk("cpu_en_run", {31'd0, cpu_en}, 1);
            chk("cpu_rst_n_run", {31'd0, cpu_rst_n}, 1);
            chk("imem_we_run", {31'd0, imem_we}, 0);
            chk("load_ready_run", {31'd0, load_ready}, 0);
            chk("cycle_count_run", {16'd0, cycle_count}, runc - 1);
            chk("err_run", {31'd0, err_timeout}, 0);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("run_cycles", runc, t.exp_cycles);
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, t.exp_err});
        chk("cycle_count", {16'd0, cycle_count}, t.exp_cycles);

        idx = 0; stall = 0; cyc = 0;
        while (idx < 32 && cyc < 500) begin
            if (t.stall4 && idx == 4 && stall < 5) begin
                dump_ready = 1'b0;
                stall++;
            end else begin
                dump_ready = ($urandom_range(99) >= 30);
            end
            #1;
            chk("dump_valid", {31'd0, dump_valid}, 1);
            chk("cpu_en_dump", {31'd0, cpu_en}, 0);
            chk("reg_raddr", {27'd0, reg_raddr}, idx);
            chk("dump_data", dump_data, regs[idx]);
            chk("dump_last", {31'd0, dump_last}, (idx == 31) ? 1 : 0);
            @(posedge clk);
            if (dump_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        start      = 1'b0;
        dump_ready = 1'b0;
        chk("dump_words", idx, 32);
        #1;
        chk("done", {31'd0, done}, 1);
        chk("busy_done", {31'd0, busy}, 0);
        chk("dump_valid_done", {31'd0, dump_valid}, 0);
        chk("cpu_en_done", {31'd0, cpu_en}, 0);
        chk("cpu_rst_n_done", {31'd0, cpu_rst_n}, 1);
        chk("cycle_count_done", {16'd0, cycle_count}, t.exp_cycles);
        chk("err_done", {31'd0, err_timeout}, {31'd0, t.exp_err});
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 0);
        chk({tag, "_cpu_en"}, {31'd0, cpu_en}, 0);
        chk({tag, "_load_ready"}, {31'd0, load_ready}, 0);
        chk({tag, "_imem_we"}, {31'd0, imem_we}, 0);
        chk({tag, "_dump_valid"}, {31'd0, dump_valid}, 0);
        chk({tag, "_err"}, {31'd0, err_timeout}, 0);
        chk({tag, "_cycle_count"}, {16'd0, cycle_count}, 0);
        chk({tag, "_imem_waddr"}, {24'd0, imem_waddr}, 0);
        chk({tag, "_reg_raddr"}, {27'd0, reg_raddr}, 0);
    endtask

    // Reset in the middle of RUN, then confirm nothing happens without start.
    task automatic reset_mid_run();
        core_mode  = 0;
        core_jump  = 32'd0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        @(negedge clk);
        load_last  = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_cpu_en", {31'd0, cpu_en}, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        rst_n      = 1'b1;
        load_valid = 1'b1;
        load_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("post_reset_imem_we", {31'd0, imem_we}, 0);
            chk("post_reset_load_ready", {31'd0, load_ready}, 0);
            chk("post_reset_busy", {31'd0, busy}, 0);
            chk("post_reset_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    vec_t vecs [8];
    vec_t rv;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_last  = 1'b0;
        dump_ready = 1'b0;
        core_mode  = 0;
        core_jump  = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        //          len  mode jump    last pat     stall cyc err
        vecs[0] = '{3,   1,   32'd0,    1, 4'b0000, 0,    4,  0};
        vecs[1] = '{3,   1,   32'd0,    1, 4'b1101, 0,    4,  0};
        vecs[2] = '{5,   0,   32'd0,    1, 4'b0000, 1,    16, 1};
        vecs[3] = '{15,  1,   32'd0,    1, 4'b0000, 0,    16, 0};
        vecs[4] = '{16,  1,   32'd0,    1, 4'b0000, 0,    16, 1};
        vecs[5] = '{256, 2,   32'd1024, 0, 4'b0000, 0,    2,  0};
        vecs[6] = '{256, 2,   32'd1020, 0, 4'b0000, 0,    16, 1};
        vecs[7] = '{1,   1,   32'd0,    1, 4'b0000, 0,    2,  0};

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        for (int i = 0; i < 10; i++) begin
            rv.len      = $urandom_range(24, 1);
            rv.mode     = $urandom_range(2, 0);
            rv.jump     = 32'($urandom_range(40, 0)) * 32'd4;
            rv.use_last = 1'b1;
            rv.pat      = 4'd0;
            rv.stall4   = ($urandom_range(1) == 1);
            model_run(rv.len, rv.mode, rv.jump, rv.exp_cycles, rv.exp_err);
            run_vec(rv);
        end

        reset_mid_run();
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
